// File: rtl/rv_itype_pkg.sv
// Shared opcode/funct constants and FSM state type for the RV32/64 OP-IMM core.
package rv_itype_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_SLLI  = 3'b001;
  localparam logic [2:0] F3_SLTI  = 3'b010;
  localparam logic [2:0] F3_SLTIU = 3'b011;
  localparam logic [2:0] F3_XORI  = 3'b100;
  localparam logic [2:0] F3_SRXI  = 3'b101;
  localparam logic [2:0] F3_ORI   = 3'b110;
  localparam logic [2:0] F3_ANDI  = 3'b111;

  localparam logic [6:0] F7_SRAI  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rv_itype_core_regfile.sv
// NREGS x XLEN register file: one async read port, one sync write port, x0 hardwired to zero.
module rv_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   i_raddr,
  output logic [XLEN-1:0] o_rdata,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata
);

  logic [XLEN-1:0] r_mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = (i_raddr == '0) ? '0 : r_mem[i_raddr];

endmodule

// File: rtl/rv_itype_core.sv
// Multi-cycle OP-IMM-only RISC-V core (FETCH/EXEC/TRAP).
// Define RV_ITYPE_SHIFT_EN to build the SLLI/SRLI/SRAI shifter; otherwise those encodings trap.
module rv_itype_core
  import rv_itype_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int PC_W  = 10
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic [31:0]     retired
);

  localparam int AW = $clog2(NREGS);

  state_t            r_state, w_state_nx;
  logic [PC_W-1:0]   r_pc;
  logic [31:0]       r_ir;
  logic [XLEN-1:0]   r_result;
  logic              r_zero;
  logic              r_illegal;
  logic [31:0]       r_retired;

  logic              w_req, w_ir_ld, w_commit, w_trap;
  logic [6:0]        w_opc;
  logic [4:0]        w_rd, w_rs1;
  logic [2:0]        w_f3;
  logic signed [XLEN-1:0] w_imm;
  logic signed [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0]   w_alu;
  logic              w_f3_ok, w_legal;

  assign w_opc = r_ir[6:0];
  assign w_rd  = r_ir[11:7];
  assign w_f3  = r_ir[14:12];
  assign w_rs1 = r_ir[19:15];
  assign w_imm = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};

`ifdef RV_ITYPE_SHIFT_EN
  localparam int SHW = $clog2(XLEN);
  // funct bits above the shift amount; the SRAI pattern lands at 0x20 (XLEN=32) or 0x10 (XLEN=64)
  localparam logic [11:0] SRAI_HI = {F7_SRAI, 5'b0} >> SHW;
  logic [SHW-1:0] w_shamt;
  logic [11:0]    w_fhi;
  assign w_shamt = r_ir[20 +: SHW];
  assign w_fhi   = r_ir[31:20] >> SHW;
`endif

  always_comb begin
    w_f3_ok = 1'b0;
    case (w_f3)
      F3_ADDI, F3_SLTI, F3_SLTIU, F3_XORI, F3_ORI, F3_ANDI: w_f3_ok = 1'b1;
`ifdef RV_ITYPE_SHIFT_EN
      F3_SLLI: w_f3_ok = (w_fhi == '0);
      F3_SRXI: w_f3_ok = (w_fhi == '0) || (w_fhi == SRAI_HI);
`endif
      default: w_f3_ok = 1'b0;
    endcase
  end

  assign w_legal = (w_opc == OPC_OP_IMM) && w_f3_ok &&
                   (int'(w_rs1) < NREGS) && (int'(w_rd) < NREGS);

  always_comb begin
    w_alu = '0;
    case (w_f3)
      F3_ADDI:  w_alu = w_rs1_val + w_imm;
      F3_SLTI:  w_alu = {{(XLEN-1){1'b0}}, (w_rs1_val < w_imm)};
      F3_SLTIU: w_alu = {{(XLEN-1){1'b0}}, ($unsigned(w_rs1_val) < $unsigned(w_imm))};
      F3_XORI:  w_alu = w_rs1_val ^ w_imm;
      F3_ORI:   w_alu = w_rs1_val | w_imm;
      F3_ANDI:  w_alu = w_rs1_val & w_imm;
`ifdef RV_ITYPE_SHIFT_EN
      F3_SLLI:  w_alu = w_rs1_val << w_shamt;
      F3_SRXI: begin
        // kept as if/else so the arithmetic shift is not coerced to unsigned
        if (r_ir[30]) w_alu = w_rs1_val >>> w_shamt;
        else          w_alu = $unsigned(w_rs1_val) >> w_shamt;
      end
`endif
      default:  w_alu = '0;
    endcase
  end

  rv_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_raddr (w_rs1[AW-1:0]),
    .o_rdata (w_rs1_val),
    .i_we    (w_commit),
    .i_waddr (w_rd[AW-1:0]),
    .i_wdata (w_alu)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_req      = 1'b0;
    w_ir_ld    = 1'b0;
    w_commit   = 1'b0;
    w_trap     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_ir_ld    = 1'b1;
          w_state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_legal) begin
          w_commit   = 1'b1;
          w_state_nx = ST_FETCH;
        end else begin
          w_trap     = 1'b1;
          w_state_nx = ST_TRAP;
        end
      end
      ST_TRAP:  w_state_nx = ST_TRAP;
      default:  w_state_nx = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_ir_ld) r_ir <= imem_rdata;
      if (w_commit) begin
        r_pc      <= r_pc + PC_W'(1);
        r_retired <= r_retired + 32'd1;
        r_result  <= w_alu;
        r_zero    <= (w_alu == '0);
      end
      if (w_trap) r_illegal <= 1'b1;
    end
  end

  // request drops as soon as reset is asserted, independent of the state register
  assign imem_req  = w_req & ~rst;
  assign imem_addr = r_pc;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;
  assign retired   = r_retired;

endmodule
